// File: rtl/sound_pkg.sv
// Shared constants and types for the sound frame sequencer and its length counters.
package sound_pkg;

   localparam int NUM_CH          = 4;
   localparam int CNT_W           = 9;
   localparam int STEP_W          = 3;
   localparam int NUM_STEPS       = 1 << STEP_W;
   localparam int DATA_W          = 8;

   // Length counter full-scale values: square/noise channels and the wave channel.
   localparam int LEN_MAX_SQ      = 64;
   localparam int LEN_MAX_WAVE    = 256;
   // Zero-based index of the wave channel (channel 3).
   localparam int WAVE_CH         = 2;

   // Bit n set means the tick fires when leaving frame step n.
   localparam logic [NUM_STEPS-1:0] STEP_LEN_MASK   = 8'b0101_0101;
   localparam logic [NUM_STEPS-1:0] STEP_SWEEP_MASK = 8'b0100_0100;
   localparam logic [NUM_STEPS-1:0] STEP_ENV_MASK   = 8'b1000_0000;

   // 33 MHz / 512 Hz frame step rate.
   localparam int CLK_DIV_DEFAULT = 64453;

   typedef logic [STEP_W-1:0] step_t;

   // Per-channel register-write controls seen by one length counter.
   typedef struct packed {
      logic trigger;
      logic len_en;
      logic len_load;
   } ch_ctl_t;

   // Full-scale length for a zero-based channel index.
   function automatic int len_max(input int ch);
      return (ch == WAVE_CH) ? LEN_MAX_WAVE : LEN_MAX_SQ;
   endfunction

endpackage

// File: rtl/sound_length_counter.sv
// One channel's length counter and its channel-active flag.
// Priority: master disable > trigger > load > length tick.
module sound_length_counter
   import sound_pkg::*;
#(
   parameter int LMAX = LEN_MAX_SQ
) (
   input  logic              I_CLK_33MHZ,
   input  logic              I_RESET_L,
   input  logic              master_en,
   input  ch_ctl_t           ctl,
   input  logic [DATA_W-1:0] len_data,
   input  logic              len_tick,
   output logic              ch_on
);

   localparam logic [CNT_W-1:0] LMAX_V    = CNT_W'(LMAX);
   localparam logic [CNT_W-1:0] DATA_MASK = CNT_W'(LMAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             on_q;
   logic             on_d;
   logic [CNT_W-1:0] load_val;

   // Register writes store the complement: data 0 means full scale.
   assign load_val = LMAX_V - (CNT_W'(len_data) & DATA_MASK);
   assign ch_on    = on_q;

   // Next counter / active flag, highest-priority event first.
   always_comb begin
      cnt_d = cnt_q;
      on_d  = on_q;
      if (!master_en) begin
         cnt_d = '0;
         on_d  = 1'b0;
      end else if (ctl.trigger) begin
         on_d = 1'b1;
         if (cnt_q == '0) cnt_d = LMAX_V;
      end else if (ctl.len_load) begin
         cnt_d = load_val;
      end else if (len_tick && ctl.len_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_ONE;
         // Expiry silences the channel in the same update as the final decrement.
         if (cnt_q == CNT_ONE) on_d = 1'b0;
      end
   end

   // Counter and active-flag state.
   always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         cnt_q <= '0;
         on_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         on_q  <= on_d;
      end
   end

endmodule

// File: rtl/sound_frame_sequencer.sv
// 512 Hz frame sequencer: prescaler, 8-step frame counter, length/sweep/envelope
// tick generation and four per-channel length counters.
module sound_frame_sequencer
   import sound_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic              I_CLK_33MHZ,
   input  logic              I_RESET_L,
   input  logic              I_MASTER_EN,
   input  logic [NUM_CH-1:0] I_TRIGGER,
   input  logic [NUM_CH-1:0] I_LEN_EN,
   input  logic [NUM_CH-1:0] I_LEN_LOAD,
   input  logic [DATA_W-1:0] I_LEN_DATA,
   output logic              O_LEN_TICK,
   output logic              O_SWEEP_TICK,
   output logic              O_ENV_TICK,
   output step_t             O_STEP,
   output logic [NUM_CH-1:0] O_CH_ON
);

   localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam step_t            STEP_ONE = STEP_W'(1);

   logic [PRE_W-1:0] pre_q;
   logic             strobe;

   // One strobe per prescaler wrap; never while the sound block is off.
   assign strobe = I_MASTER_EN && (pre_q == PRE_LAST);

   // Prescaler: free-runs while enabled, held at zero while disabled so the
   // first strobe after enable lands a full CLK_DIV cycles later.
   always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         pre_q <= '0;
      end else if (!I_MASTER_EN || strobe) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PRE_ONE;
      end
   end

   // Frame step counter and one-cycle ticks decoded from the step being left.
   always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         O_STEP       <= '0;
         O_LEN_TICK   <= 1'b0;
         O_SWEEP_TICK <= 1'b0;
         O_ENV_TICK   <= 1'b0;
      end else if (!I_MASTER_EN) begin
         O_STEP       <= '0;
         O_LEN_TICK   <= 1'b0;
         O_SWEEP_TICK <= 1'b0;
         O_ENV_TICK   <= 1'b0;
      end else begin
         O_LEN_TICK   <= strobe && STEP_LEN_MASK[O_STEP];
         O_SWEEP_TICK <= strobe && STEP_SWEEP_MASK[O_STEP];
         O_ENV_TICK   <= strobe && STEP_ENV_MASK[O_STEP];
         if (strobe) O_STEP <= O_STEP + STEP_ONE;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ch_ctl_t ctl;

      assign ctl = '{trigger: I_TRIGGER[c], len_en: I_LEN_EN[c], len_load: I_LEN_LOAD[c]};

      sound_length_counter #(
         .LMAX (len_max(c))
      ) u_len (
         .I_CLK_33MHZ (I_CLK_33MHZ),
         .I_RESET_L   (I_RESET_L),
         .master_en   (I_MASTER_EN),
         .ctl         (ctl),
         .len_data    (I_LEN_DATA),
         .len_tick    (O_LEN_TICK),
         .ch_on       (O_CH_ON[c])
      );
   end

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Directed bench for sound_frame_sequencer with CLK_DIV=4.
module tb_sound_frame_sequencer;

   logic       clk       = 1'b0;
   logic       rst_l     = 1'b0;
   logic       master_en = 1'b0;
   logic [3:0] trig      = '0;
   logic [3:0] len_en    = '0;
   logic [3:0] len_load  = '0;
   logic [7:0] len_data  = '0;

   logic       len_tick;
   logic       sweep_tick;
   logic       env_tick;
   logic [2:0] step;
   logic [3:0] ch_on;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sound_frame_sequencer #(.CLK_DIV(4)) dut (
      .I_CLK_33MHZ  (clk),
      .I_RESET_L    (rst_l),
      .I_MASTER_EN  (master_en),
      .I_TRIGGER    (trig),
      .I_LEN_EN     (len_en),
      .I_LEN_LOAD   (len_load),
      .I_LEN_DATA   (len_data),
      .O_LEN_TICK   (len_tick),
      .O_SWEEP_TICK (sweep_tick),
      .O_ENV_TICK   (env_tick),
      .O_STEP       (step),
      .O_CH_ON      (ch_on)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges and park 1 ns after the last one.
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bounded wait until the length tick is high at a sample point.
   task automatic wait_len_tick();
      for (int i = 0; i < 64 && len_tick !== 1'b1; i++) cyc();
      chk("wait_len_tick", 32'(len_tick), 1);
   endtask

   // Drop master enable for one edge, then raise it at the current sample point.
   task automatic restart();
      master_en = 1'b0;
      trig      = '0;
      len_en    = '0;
      len_load  = '0;
      cyc();
      master_en = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lm;
      logic [7:0] sm;
      logic [7:0] em;
      int nl, ns, ne;
      lm = 8'b0101_0101;
      sm = 8'b0100_0100;
      em = 8'b1000_0000;
      nl = 0; ns = 0; ne = 0;

      // Reset state
      cyc(2);
      chk("rst_step",  32'(step), 0);
      chk("rst_ch_on", 32'(ch_on), 0);
      chk("rst_ticks", 32'({len_tick, sweep_tick, env_tick}), 0);
      rst_l = 1'b1;
      cyc(3);
      chk("idle_step", 32'(step), 0);

      // 1: 32 step strobes after master on
      restart();
      for (int k = 1; k <= 128; k++) begin
         int sexp, left, el, es, ee;
         cyc();
         sexp = (k / 4) % 8;
         left = (k % 4 == 0) ? ((k / 4) - 1) % 8 : 0;
         el   = ((k % 4 == 0) && lm[left]) ? 1 : 0;
         es   = ((k % 4 == 0) && sm[left]) ? 1 : 0;
         ee   = ((k % 4 == 0) && em[left]) ? 1 : 0;
         chk("s1_step",  32'(step), sexp);
         chk("s1_len",   32'(len_tick), el);
         chk("s1_sweep", 32'(sweep_tick), es);
         chk("s1_env",   32'(env_tick), ee);
         nl += int'(len_tick);
         ns += int'(sweep_tick);
         ne += int'(env_tick);
      end
      chk("s1_len_count",   nl, 16);
      chk("s1_sweep_count", ns, 8);
      chk("s1_env_count",   ne, 4);

      // 2: channel 1 loaded with 62 expires on the 2nd length tick
      restart();
      len_load = 4'b0001;
      len_data = 8'd62;
      len_en   = 4'b0001;
      cyc();
      len_load = '0;
      trig     = 4'b0001;
      cyc();
      trig = '0;
      chk("s2_on_after_trig", 32'(ch_on[0]), 1);
      wait_len_tick();
      cyc();
      chk("s2_on_after_tick1", 32'(ch_on[0]), 1);
      wait_len_tick();
      cyc();
      chk("s2_off_after_tick2", 32'(ch_on[0]), 0);

      // 3: channel 3 loaded with 0 lasts exactly 256 ticks
      restart();
      len_load = 4'b0100;
      len_data = 8'd0;
      cyc();
      len_load = '0;
      trig     = 4'b0100;
      len_en   = 4'b0100;
      cyc();
      trig = '0;
      chk("s3_on_after_trig", 32'(ch_on[2]), 1);
      for (int n = 1; n <= 256; n++) begin
         wait_len_tick();
         cyc();
         if (n == 255) chk("s3_on_at_255", 32'(ch_on[2]), 1);
         if (n == 256) chk("s3_off_at_256", 32'(ch_on[2]), 0);
      end

      // 4: trigger with zero counter and length disabled; trigger coincident with tick
      restart();
      trig = 4'b0010;
      cyc();
      trig = '0;
      chk("s4_on",  32'(ch_on[1]), 1);
      chk("s4_cnt", 32'(dut.g_ch[1].u_len.cnt_q), 64);
      cyc(100);
      chk("s4_on_hold",  32'(ch_on[1]), 1);
      chk("s4_cnt_hold", 32'(dut.g_ch[1].u_len.cnt_q), 64);
      len_en = 4'b0010;
      wait_len_tick();
      trig = 4'b0010;
      cyc();
      trig = '0;
      chk("s4_cnt_trig_tick", 32'(dut.g_ch[1].u_len.cnt_q), 64);
      wait_len_tick();
      cyc();
      chk("s4_cnt_dec", 32'(dut.g_ch[1].u_len.cnt_q), 63);
      chk("s4_on_dec",  32'(ch_on[1]), 1);

      // 5: master disable mid-frame
      restart();
      trig = 4'hF;
      cyc();
      trig = '0;
      chk("s5_all_on", 32'(ch_on), 32'hF);
      cyc(9);
      chk("s5_step_mid", 32'(step), 2);
      master_en = 1'b0;
      cyc();
      chk("s5_off_ch_on", 32'(ch_on), 0);
      chk("s5_off_step",  32'(step), 0);
      trig     = 4'hF;
      len_load = 4'hF;
      len_data = 8'd5;
      cyc();
      trig     = '0;
      len_load = '0;
      chk("s5_trig_disabled", 32'(ch_on), 0);
      chk("s5_load_disabled", 32'(dut.g_ch[0].u_len.cnt_q), 0);
      cyc(8);
      chk("s5_no_ticks", 32'({len_tick, sweep_tick, env_tick, step}), 0);

      // 6: reset asserted while a length tick is high
      restart();
      trig = 4'b0001;
      cyc();
      trig = '0;
      chk("s6_on", 32'(ch_on[0]), 1);
      wait_len_tick();
      chk("s6_step_before", 32'(step), 1);
      #2;
      rst_l = 1'b0;
      #1;
      chk("s6_rst_len",   32'(len_tick), 0);
      chk("s6_rst_step",  32'(step), 0);
      chk("s6_rst_ch_on", 32'(ch_on), 0);
      chk("s6_rst_other", 32'({sweep_tick, env_tick}), 0);
      cyc();
      rst_l = 1'b1;
      cyc(3);
      chk("s6_post_no_tick", 32'(len_tick), 0);
      cyc();
      chk("s6_post_tick", 32'(len_tick), 1);
      chk("s6_post_step", 32'(step), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
